// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared geometry, default rotation period and the
//               commit-state type for the LED matrix frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  // Geometry of the matrix the scanner drives
  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;

  // 10 Hz rotation tick at a 27 MHz system clock
  localparam int DEFAULT_ROT_DIV = 2700000;

  // IDLE accepts writes; PENDING waits for the next frame boundary to swap
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_frame_buffer_if
// Description : Row-write / commit / frame-sync bundle between a frame
//               producer and the matrix frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_frame_buffer_if;
  import matrix_pkg::*;

  logic                               wr_valid;
  logic                               wr_ready;
  logic [2:0]                         wr_row;
  logic [MATRIX_COLS-1:0]             wr_data;
  logic                               commit;
  logic                               frame_start;
  logic                               rot_en;
  logic                               busy;
  logic [MATRIX_ROWS*MATRIX_COLS-1:0] led_data;

  // Producer / scanner side
  modport master (
    output wr_valid, wr_row, wr_data, commit, frame_start, rot_en,
    input  wr_ready, busy, led_data
  );

  // Frame buffer side
  modport slave (
    input  wr_valid, wr_row, wr_data, commit, frame_start, rot_en,
    output wr_ready, busy, led_data
  );

endinterface
`default_nettype wire

// File: rtl/matrix_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : matrix_tick_gen
// Description : Free-running divider producing a one-cycle tick every
//               ROT_DIV cycles while enabled; parked at zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_tick_gen
  import matrix_pkg::*;
#(
  parameter int ROT_DIV = DEFAULT_ROT_DIV
) (
  input  wire  sys_clock,
  input  wire  sys_reset,
  input  wire  enable,
  output logic tick
);

  localparam int            CW     = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(ROT_DIV - 1);

  logic [CW-1:0] r_count;

  // Count 0..ROT_DIV-1 while enabled, wrap on the last value, hold at 0 otherwise
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      r_count <= '0;
    end else if (!enable) begin
      r_count <= '0;
    end else if (r_count == C_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/matrix_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_frame_buffer
// Description : Double-buffered 8x8 LED frame store. Rows are written into
//               the back bank; a commit publishes it to the front bank at the
//               next frame boundary so the scanner never shows a torn frame.
//               The front bank can optionally rotate left on a slow tick.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_frame_buffer
  import matrix_pkg::*;
#(
  parameter int ROT_DIV = DEFAULT_ROT_DIV,
  parameter int ROWS    = MATRIX_ROWS,
  parameter int COLS    = MATRIX_COLS
) (
  input  wire                   sys_clock,
  input  wire                   sys_reset,
  matrix_frame_buffer_if.slave  bus
);

  // The 3-bit row index and 8-bit row bus only make sense for an 8x8 matrix
  if (ROWS != MATRIX_ROWS || COLS != MATRIX_COLS) begin : g_bad_geometry
    $error("matrix_frame_buffer supports only an 8x8 matrix");
  end

  fb_state_t       r_state;
  fb_state_t       w_state_next;
  logic [COLS-1:0] r_back  [ROWS];
  logic [COLS-1:0] r_front [ROWS];
  logic            w_tick;
  logic            w_wr_fire;
  logic            w_swap;

  matrix_tick_gen #(
    .ROT_DIV (ROT_DIV)
  ) u_tick_gen (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .enable    (bus.rot_en),
    .tick      (w_tick)
  );

  // Commit state register
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs; a frame_start seen in IDLE never swaps
  always_comb begin
    w_state_next = r_state;
    bus.wr_ready = 1'b0;
    bus.busy     = 1'b0;
    w_wr_fire    = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.wr_ready = 1'b1;
        w_wr_fire    = bus.wr_valid;
        if (bus.commit) begin
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        bus.busy = 1'b1;
        if (bus.frame_start) begin
          w_swap       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Back bank takes accepted row writes; writes during PENDING are dropped
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      for (int i = 0; i < ROWS; i++) begin
        r_back[i] <= '0;
      end
    end else if (w_wr_fire) begin
      r_back[bus.wr_row] <= bus.wr_data;
    end
  end

  // Front bank: swap has priority over a coincident rotation tick
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      for (int i = 0; i < ROWS; i++) begin
        r_front[i] <= '0;
      end
    end else if (w_swap) begin
      for (int i = 0; i < ROWS; i++) begin
        r_front[i] <= r_back[i];
      end
    end else if (w_tick) begin
      for (int i = 0; i < ROWS; i++) begin
        r_front[i] <= {r_front[i][COLS-2:0], r_front[i][COLS-1]};
      end
    end
  end

  // Flatten the front bank for the scanner, row r on bits [8r+7:8r]
  always_comb begin
    bus.led_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      bus.led_data[r*COLS +: COLS] = r_front[r];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_frame_buffer
// Description : Directed self-checking bench for matrix_frame_buffer with a
//               four-cycle rotation period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_frame_buffer;

  logic sys_clock = 1'b0;
  logic sys_reset;
  int   n_vec = 0;
  int   n_err = 0;

  matrix_frame_buffer_if bus ();

  matrix_frame_buffer #(
    .ROT_DIV (4)
  ) dut (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .bus       (bus.slave)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 ns past the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic write_row(input logic [2:0] row, input logic [7:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_row   = row;
    bus.wr_data  = data;
    step(1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    step(1);
    bus.commit = 1'b0;
  endtask

  task automatic pulse_frame_start();
    bus.frame_start = 1'b1;
    step(1);
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.wr_valid    = 1'b0;
    bus.wr_row      = 3'd0;
    bus.wr_data     = 8'h00;
    bus.commit      = 1'b0;
    bus.frame_start = 1'b0;
    bus.rot_en      = 1'b0;
    sys_reset       = 1'b1;

    // Reset state
    #1;
    check("reset_led",   bus.led_data, 64'h0);
    check("reset_ready", 64'(bus.wr_ready), 64'h1);
    check("reset_busy",  64'(bus.busy), 64'h0);
    step(2);
    sys_reset = 1'b0;

    // Diagonal frame: write, commit, swap at frame boundary
    for (int r = 0; r < 8; r++) begin
      write_row(3'(r), 8'(1 << r));
    end
    check("led_before_commit", bus.led_data, 64'h0);
    pulse_commit();
    check("commit_busy",  64'(bus.busy), 64'h1);
    check("commit_ready", 64'(bus.wr_ready), 64'h0);
    step(9);
    bus.frame_start = 1'b1;
    check("led_before_swap",  bus.led_data, 64'h0);
    check("busy_before_swap", 64'(bus.busy), 64'h1);
    step(1);
    bus.frame_start = 1'b0;
    check("diag_swap",       bus.led_data, 64'h8040201008040201);
    check("busy_after_swap", 64'(bus.busy), 64'h0);
    check("ready_after_swap", 64'(bus.wr_ready), 64'h1);

    // Commit coincident with frame_start must wait for the next frame
    write_row(3'd2, 8'h5A);
    bus.commit      = 1'b1;
    bus.frame_start = 1'b1;
    step(1);
    bus.commit      = 1'b0;
    bus.frame_start = 1'b0;
    check("same_cycle_no_swap", bus.led_data, 64'h8040201008040201);
    check("same_cycle_busy",    64'(bus.busy), 64'h1);

    // Write attempted while PENDING is refused
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'd3;
    bus.wr_data  = 8'hAA;
    check("pending_ready", 64'(bus.wr_ready), 64'h0);
    step(1);
    bus.wr_valid = 1'b0;
    check("pending_busy_held", 64'(bus.busy), 64'h1);
    step(2);
    pulse_frame_start();
    check("swap_no_aa",      bus.led_data, 64'h80402010085A0201);
    check("busy_after_swap2", 64'(bus.busy), 64'h0);

    // Rotation of a single lit pixel
    write_row(3'd0, 8'h80);
    for (int r = 1; r < 8; r++) begin
      write_row(3'(r), 8'h00);
    end
    pulse_commit();
    pulse_frame_start();
    check("rot_start", bus.led_data, 64'h80);
    bus.rot_en = 1'b1;
    step(3);
    check("rot_before_tick", bus.led_data, 64'h80);
    step(1);
    check("rot_tick1", bus.led_data, 64'h01);
    step(4);
    check("rot_tick2", bus.led_data, 64'h02);
    bus.rot_en = 1'b0;
    step(6);
    check("rot_frozen", bus.led_data, 64'h02);

    // Rotation tick landing on the swap edge: swap wins
    write_row(3'd1, 8'hC3);
    pulse_commit();
    bus.rot_en = 1'b1;
    step(3);
    check("pending_front_held", bus.led_data, 64'h02);
    pulse_frame_start();
    check("swap_beats_tick", bus.led_data, 64'hC380);
    check("swap_tick_busy",  64'(bus.busy), 64'h0);
    step(3);
    check("post_swap_hold", bus.led_data, 64'hC380);
    step(1);
    check("post_swap_rot", bus.led_data, 64'h8701);
    bus.rot_en = 1'b0;

    // Asynchronous reset while PENDING discards the commit
    pulse_commit();
    check("pre_reset_busy", 64'(bus.busy), 64'h1);
    #2;
    sys_reset = 1'b1;
    #1;
    check("async_reset_led",   bus.led_data, 64'h0);
    check("async_reset_ready", 64'(bus.wr_ready), 64'h1);
    check("async_reset_busy",  64'(bus.busy), 64'h0);
    step(1);
    sys_reset       = 1'b0;
    bus.wr_valid    = 1'b1;
    bus.wr_row      = 3'd0;
    bus.wr_data     = 8'h3C;
    bus.frame_start = 1'b1;
    step(1);
    bus.wr_valid    = 1'b0;
    bus.frame_start = 1'b0;
    check("no_swap_after_reset", bus.led_data, 64'h0);
    check("idle_after_reset",    64'(bus.busy), 64'h0);
    pulse_commit();
    pulse_frame_start();
    check("first_write_after_reset", bus.led_data, 64'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_frame_buffer.md
MATRIX_FRAME_BUFFER -- requirements
Module: matrix_frame_buffer

Interface
REQ-001 SHALL have parameter ROT_DIV, default 2700000, rotation tick period in sys_clock cycles (10 Hz at 27 MHz).
REQ-002 SHALL have parameter ROWS, default 8, matrix row count; COLS, default 8, matrix column count.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 sys_clock  input  1  sole clock, all state on rising edge.
REQ-005 sys_reset  input  1  asynchronous active-high reset.
REQ-006 wr_valid  input  1  row-write request.
REQ-007 wr_ready  output  1  buffer can accept a row write.
REQ-008 wr_row  input  3  target row index, 0..7.
REQ-009 wr_data  input  8  row pixel bits, bit7 = leftmost column.
REQ-010 commit  input  1  single-cycle pulse: publish back bank at next frame boundary.
REQ-011 frame_start  input  1  single-cycle pulse from matrix scanner at start of row 0.
REQ-012 rot_en  input  1  enable periodic left rotation of displayed frame.
REQ-013 busy  output  1  commit pending, swap not yet done.
REQ-014 led_data  output  64  displayed frame, row r on bits [8r+7:8r], driven straight to scanner.

Function
REQ-015 SHALL hold two 8x8 banks: back (write target) and front (drives led_data, registered, no combinational path from inputs).
REQ-016 SHALL implement FSM IDLE/PENDING; wr_ready = (state == IDLE); busy = (state == PENDING).
REQ-017 Write handshake: wr_valid & wr_ready at edge n -> back[wr_row] = wr_data visible from n+1; wr_valid while not ready SHALL be ignored, not queued.
REQ-018 IDLE + commit -> PENDING; commit in PENDING SHALL be ignored.
REQ-019 PENDING + frame_start -> front = back (all 8 rows, same edge), back retained, -> IDLE; led_data changes only at that edge.
REQ-020 commit and frame_start in same IDLE cycle: enter PENDING, swap on the following frame_start, never the current one.
REQ-021 wr_valid and commit in same IDLE cycle: write accepted and included in the pending snapshot.
REQ-022 Rotation counter: counts 0..ROT_DIV-1 while rot_en=1, wraps to 0; held at 0 while rot_en=0.
REQ-023 At counter == ROT_DIV-1 with rot_en=1: every front row SHALL become {row[6:0], row[7]} on that edge.
REQ-024 Swap and rotation tick on same edge: swap wins, rotation for that tick skipped, counter wraps normally.
REQ-025 Rotation SHALL NOT modify back bank; a later commit overwrites rotated front.
REQ-026 Out-of-range wr_row impossible (3-bit); ROWS/COLS other than 8 SHALL be rejected at elaboration.

Reset
REQ-027 sys_reset=1 SHALL immediately force: state IDLE, back all 0, front all 0 (led_data = 0), counter 0, wr_ready=1, busy=0.
REQ-028 Reset mid-PENDING SHALL discard the pending commit; no swap after release.
REQ-029 First edge after reset deassertion SHALL accept writes normally.

Structure
REQ-030 Shared package matrix_pkg SHALL hold ROWS, COLS, default ROT_DIV, and the IDLE/PENDING state type.
REQ-031 Rotation counter SHALL be sub-module matrix_tick_gen (inputs sys_clock, sys_reset, enable; output tick), parameterised by ROT_DIV.
REQ-032 Target size 120-400 RTL lines total.

Verification (bench uses ROT_DIV=4)
REQ-033 Reset: assert sys_reset mid-run -> led_data=0, wr_ready=1, busy=0 without a clock edge.
REQ-034 Write rows 0..7 = 8'h01..8'h80, commit, frame_start 10 cycles later -> led_data = 64'h8040201008040201 on edge after frame_start, busy 1->0 same edge.
REQ-035 Commit and frame_start same cycle -> led_data unchanged; next frame_start -> swap.
REQ-036 wr_valid during PENDING with wr_data=8'hAA -> wr_ready=0, back unchanged; post-swap led_data has no 8'hAA.
REQ-037 front row0=8'h80, rot_en=1 -> row0 = 8'h01 after 4 cycles, 8'h02 after 8; rot_en=0 -> frozen.
REQ-038 Rotation tick coincident with swap -> led_data equals unrotated back contents, next tick rotates.
